// File: rtl/ad_pingpong_buf.sv
// ADC sample ping-pong buffer: fills one bank with samples of the selected channel
// while the TX framer drains the other, announcing each full bank via ad_switch/ad_cnt.
module ad_pingpong_buf #(
    parameter int unsigned DATA_NBIT = 16,
    parameter int unsigned SIZE      = 256,
    parameter int unsigned CNT_NBIT  = 32,
    parameter int unsigned CHN_NBIT  = 3
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic                 ad_acq_en,
    input  logic [CHN_NBIT-1:0]  ad_chn,
    input  logic                 adc_vd,
    input  logic [CHN_NBIT-1:0]  adc_chn,
    input  logic [DATA_NBIT-1:0] adc_data,
    input  logic                 ad_rd,
    output logic [DATA_NBIT-1:0] ad_data,
    output logic [CNT_NBIT-1:0]  ad_cnt,
    output logic                 ad_switch,
    output logic                 ad_ovf
);

    localparam int unsigned PTR_NBIT = $clog2(SIZE);
    localparam int unsigned RC_NBIT  = PTR_NBIT + 1;
    localparam int unsigned MEM_WORDS = 2 * SIZE;
    localparam logic [RC_NBIT-1:0]  RC_FULL  = RC_NBIT'(SIZE);
    localparam logic [PTR_NBIT-1:0] PTR_LAST = PTR_NBIT'(SIZE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [DATA_NBIT-1:0] mem [MEM_WORDS];

    logic [1:0]          state, state_nx;
    logic                acq_prev;
    logic                wb, wb_nx;
    logic                rb, rb_nx;
    logic [PTR_NBIT-1:0] wr_ptr, wr_ptr_nx;
    logic [PTR_NBIT-1:0] rd_ptr, rd_ptr_nx;
    logic [RC_NBIT-1:0]  rd_cnt, rd_cnt_nx;
    logic [CNT_NBIT-1:0] cnt_nx;
    logic                switch_nx;
    logic                ovf_nx;
    logic                acq_rise;
    logic                match;
    logic                rd_go;
    logic                wr_en;
    logic                do_switch;

    // Next-state logic; a switch overrides any concurrent read advance.
    always_comb begin
        state_nx  = state;
        wb_nx     = wb;
        rb_nx     = rb;
        wr_ptr_nx = wr_ptr;
        cnt_nx    = ad_cnt;
        switch_nx = ad_switch;
        ovf_nx    = ad_ovf;
        wr_en     = 1'b0;
        do_switch = 1'b0;
        acq_rise  = ad_acq_en & ~acq_prev;
        match     = adc_vd && (adc_chn == ad_chn);
        rd_go     = ad_rd && !rd_cnt[PTR_NBIT];
        rd_ptr_nx = rd_ptr + PTR_NBIT'(rd_go);
        rd_cnt_nx = rd_cnt + RC_NBIT'(rd_go);

        if (acq_rise) begin
            state_nx  = ST_FILL;
            wb_nx     = 1'b0;
            wr_ptr_nx = '0;
            rd_ptr_nx = '0;
            rd_cnt_nx = RC_FULL;
            cnt_nx    = '0;
            ovf_nx    = 1'b0;
        end else if (!ad_acq_en) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_FILL: begin
                    if (match) begin
                        wr_en     = 1'b1;
                        wr_ptr_nx = wr_ptr + PTR_NBIT'(1);
                        if (wr_ptr == PTR_LAST) begin
                            // A drain completing this very cycle still allows the switch.
                            if (rd_cnt_nx == RC_FULL) do_switch = 1'b1;
                            else                      state_nx  = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (match) ovf_nx = 1'b1;
                    if (rd_cnt == RC_FULL) begin
                        do_switch = 1'b1;
                        state_nx  = ST_FILL;
                    end
                end
                default: ;
            endcase
        end

        if (do_switch) begin
            rb_nx     = wb;
            wb_nx     = ~wb;
            wr_ptr_nx = '0;
            rd_ptr_nx = '0;
            rd_cnt_nx = '0;
            cnt_nx    = ad_cnt + CNT_NBIT'(1);
            switch_nx = ~ad_switch;
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            acq_prev  <= 1'b0;
            wb        <= 1'b0;
            rb        <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_cnt    <= RC_FULL;
            ad_cnt    <= '0;
            ad_switch <= 1'b0;
            ad_ovf    <= 1'b0;
            ad_data   <= '0;
        end else begin
            state     <= state_nx;
            acq_prev  <= ad_acq_en;
            wb        <= wb_nx;
            rb        <= rb_nx;
            wr_ptr    <= wr_ptr_nx;
            rd_ptr    <= rd_ptr_nx;
            rd_cnt    <= rd_cnt_nx;
            ad_cnt    <= cnt_nx;
            ad_switch <= switch_nx;
            ad_ovf    <= ovf_nx;
            ad_data   <= mem[{rb, rd_ptr}];
        end
    end

    // Sample storage, addressed {bank, pointer}; contents are not reset.
    always_ff @(posedge mclk) begin
        if (wr_en) mem[{wb, wr_ptr}] <= adc_data;
    end

endmodule

// File: tb/tb_ad_pingpong_buf.sv
// Self-checking bench for ad_pingpong_buf: directed scenarios plus random traffic,
// compared every cycle against a bank/frame-level reference model.
module tb_ad_pingpong_buf;

    localparam int SIZE = 8;
    localparam int ST_IDLE = 0, ST_FILL = 1, ST_WAIT = 2;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ad_acq_en = 1'b0;
    logic [2:0]  ad_chn = '0;
    logic        adc_vd = 1'b0;
    logic [2:0]  adc_chn = '0;
    logic [15:0] adc_data = '0;
    logic        ad_rd = 1'b0;
    logic [15:0] ad_data;
    logic [31:0] ad_cnt;
    logic        ad_switch;
    logic        ad_ovf;

    ad_pingpong_buf #(.DATA_NBIT(16), .SIZE(SIZE), .CNT_NBIT(32), .CHN_NBIT(3)) dut (
        .mclk(mclk), .rst_n(rst_n), .ad_acq_en(ad_acq_en), .ad_chn(ad_chn),
        .adc_vd(adc_vd), .adc_chn(adc_chn), .adc_data(adc_data), .ad_rd(ad_rd),
        .ad_data(ad_data), .ad_cnt(ad_cnt), .ad_switch(ad_switch), .ad_ovf(ad_ovf)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;

    // Reference model: two banks, write/read positions, frame bookkeeping.
    int          m_st, m_wb, m_rb, m_wp, m_rp, m_rc;
    bit          m_prev, m_sw, m_ovf, m_dv;
    logic [31:0] m_cnt;
    logic [15:0] m_data;
    logic [15:0] m_mem [2][SIZE];
    bit          m_val [2][SIZE];

    bit          cur_acq = 1'b0;
    logic [2:0]  cur_sel = 3'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = ST_IDLE; m_prev = 0; m_wb = 0; m_rb = 1; m_wp = 0; m_rp = 0; m_rc = SIZE;
        m_cnt = '0; m_sw = 0; m_ovf = 0; m_data = '0; m_dv = 1;
    endtask

    // Drive one cycle, advance the model across the coming edge, check at the next falling edge.
    task automatic step(input bit vd, input logic [2:0] ch, input logic [15:0] d, input bit rd);
        bit rise, match, rdgo, sw;
        logic [15:0] nd;
        bit nv;
        ad_acq_en = cur_acq; ad_chn = cur_sel;
        adc_vd = vd; adc_chn = ch; adc_data = d; ad_rd = rd;

        nd = m_mem[m_rb][m_rp];
        nv = m_val[m_rb][m_rp];
        rise = cur_acq && !m_prev;
        m_prev = cur_acq;
        match = vd && (ch == cur_sel);
        rdgo = rd && (m_rc < SIZE);
        sw = 0;
        if (rise) begin
            m_wb = 0; m_wp = 0; m_cnt = '0; m_rc = SIZE; m_ovf = 0; m_rp = 0; m_st = ST_FILL;
        end else begin
            if (!cur_acq) begin
                m_st = ST_IDLE;
            end else if (m_st == ST_FILL && match) begin
                m_mem[m_wb][m_wp] = d;
                m_val[m_wb][m_wp] = 1;
                if (m_wp == SIZE - 1) begin
                    if (m_rc + int'(rdgo) == SIZE) sw = 1;
                    else m_st = ST_WAIT;
                end
                m_wp = (m_wp + 1) % SIZE;
            end else if (m_st == ST_WAIT) begin
                if (match) m_ovf = 1;
                if (m_rc == SIZE) begin sw = 1; m_st = ST_FILL; end
            end
            if (sw) begin
                m_rb = m_wb; m_wb = 1 - m_wb; m_wp = 0; m_rp = 0; m_rc = 0;
                m_cnt = m_cnt + 32'd1; m_sw = !m_sw;
            end else begin
                m_rp = (m_rp + int'(rdgo)) % SIZE;
                m_rc = m_rc + int'(rdgo);
            end
        end
        m_data = nd;
        m_dv = nv;

        @(negedge mclk);
        chk("ad_cnt", 64'(ad_cnt), 64'(m_cnt));
        chk("ad_switch", 64'(ad_switch), 64'(m_sw));
        chk("ad_ovf", 64'(ad_ovf), 64'(m_ovf));
        if (m_dv) chk("ad_data", 64'(ad_data), 64'(m_data));
    endtask

    task automatic idle(input int n, input bit rd);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 16'h0, rd);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_data", 64'(ad_data), 64'h0);
        chk("rst_cnt", 64'(ad_cnt), 64'h0);
        chk("rst_switch", 64'(ad_switch), 64'h0);
        chk("rst_ovf", 64'(ad_ovf), 64'h0);
        model_reset();
        @(negedge mclk);
        rst_n = 1'b1;
    endtask

    task automatic restart();
        cur_acq = 0; idle(1, 0);
        cur_acq = 1; idle(1, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge mclk);
        do_reset();

        // Reset in the middle of a fill
        cur_sel = 3'd2; cur_acq = 1; idle(1, 0);
        for (int k = 1; k <= 3; k++) step(1'b1, 3'd2, 16'(k * 16'h0101), 1'b0);
        cur_acq = 0;
        do_reset();
        idle(2, 0);

        // First frame with channel filtering
        cur_acq = 1; idle(1, 0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 3'd5, 16'hDEAD, 1'b0);
            step(1'b1, 3'd2, 16'(k * 16'h0101), 1'b0);
        end
        chk("first_switch", 64'(ad_switch), 64'h1);
        chk("first_cnt", 64'(ad_cnt), 64'h1);
        idle(1, 0);
        chk("first_word", 64'(ad_data), 64'h0101);

        // Drain with spaced reads
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 3'd0, 16'h0, 1'b1);
            idle(1, 0);
        end

        // Continuous ping-pong: write and read every cycle
        restart();
        for (int i = 1; i <= 24; i++) step(1'b1, 3'd2, 16'(16'h1000 + i), 1'b1);
        chk("pp_cnt", 64'(ad_cnt), 64'h3);
        chk("pp_ovf", 64'(ad_ovf), 64'h0);
        idle(10, 1);

        // Overflow: no reads while two banks' worth plus two arrive
        restart();
        for (int i = 1; i <= 18; i++) step(1'b1, 3'd2, 16'(16'h2000 + i), 1'b0);
        chk("ovf_set", 64'(ad_ovf), 64'h1);
        chk("ovf_cnt", 64'(ad_cnt), 64'h1);
        idle(8, 1);
        idle(2, 0);
        chk("ovf_cnt2", 64'(ad_cnt), 64'h2);
        idle(10, 1);

        // Stop mid-frame, then restart
        for (int i = 1; i <= 5; i++) step(1'b1, 3'd2, 16'(16'h3000 + i), 1'b0);
        cur_acq = 0; idle(3, 0);
        chk("stop_cnt", 64'(ad_cnt), 64'h2);
        cur_acq = 1; idle(1, 0);
        chk("restart_cnt", 64'(ad_cnt), 64'h0);
        chk("restart_ovf", 64'(ad_ovf), 64'h0);
        for (int i = 1; i <= 8; i++) step(1'b1, 3'd2, 16'(16'h4000 + i), 1'b0);
        chk("restart_cnt1", 64'(ad_cnt), 64'h1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] ch;
            if (n == 1500) begin
                do_reset();
                cur_acq = 0;
            end
            if (cur_acq ? ($urandom_range(99) < 2) : ($urandom_range(99) < 40)) cur_acq = !cur_acq;
            if ($urandom_range(199) == 0) cur_sel = 3'($urandom_range(7));
            ch = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : cur_sel;
            step(1'($urandom_range(99) < 70), ch, 16'($urandom), 1'($urandom_range(99) < 45));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
